pbkdf2_job_ctrl: RTL and testbench

PBKDF2_JOB_CTRL -- requirements
Module: pbkdf2_job_ctrl

---
 rtl/pbkdf2_job_ctrl_pkg.sv | 18 +
 rtl/pbkdf2_job_ctrl.sv | 157 +++++++++++++++
 tb/tb_pbkdf2_job_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbkdf2_job_ctrl_pkg.sv
// Shared types and sizes for the PBKDF2 job controller: FSM states and the
// byte counts of the password, salt and digest fields.
package pbkdf2_job_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        SEND
    } state_e;

    localparam int PASS_BYTES = 80;
    localparam int SALT_BYTES = 128;
    localparam int HASH_BYTES = 32;
    localparam int JOB_BYTES  = PASS_BYTES + SALT_BYTES;

endpackage

// File: rtl/pbkdf2_job_ctrl.sv
// Job controller around pbkdf2_80_128_32: loads a 208-byte password/salt job
// from a byte stream, starts the core, watchdogs it, and streams the digest out.
module pbkdf2_job_ctrl
    import pbkdf2_job_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 65535
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [639:0]  pass,
    output logic [1023:0] salt,
    output logic          enable,
    input  logic [255:0]  hash,
    input  logic          hash_done,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          timeout
);

    localparam int              WD_W      = $clog2(WAIT_LIMIT + 1);
    localparam logic [7:0]      LAST_BYTE = 8'(JOB_BYTES - 1);
    localparam logic [4:0]      LAST_HASH = 5'(HASH_BYTES - 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(WAIT_LIMIT);

    state_e          state_q, state_d;
    logic [7:0]      load_cnt_q, load_cnt_d;
    logic [4:0]      send_cnt_q, send_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [639:0]    pass_q, pass_d;
    logic [1023:0]   salt_q, salt_d;
    logic [255:0]    cap_q, cap_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            enable_q, enable_d;
    logic            timeout_q, timeout_d;

    logic            rx_accept;
    logic [6:0]      salt_idx;
    logic [4:0]      send_nxt;

    assign rx_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign rx_accept = rx_valid && rx_ready;
    assign salt_idx  = 7'(load_cnt_q - 8'(PASS_BYTES));
    assign send_nxt  = send_cnt_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        send_cnt_d = send_cnt_q;
        wd_d       = wd_q;
        pass_d     = pass_q;
        salt_d     = salt_q;
        cap_d      = cap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        enable_d   = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                // load_cnt_q is always 0 in IDLE, so it doubles as the byte index
                if (rx_accept) begin
                    if (load_cnt_q < 8'(PASS_BYTES)) begin
                        pass_d[{load_cnt_q[6:0], 3'b000} +: 8] = rx_data;
                    end else begin
                        salt_d[{salt_idx, 3'b000} +: 8] = rx_data;
                    end
                    if (load_cnt_q == LAST_BYTE) begin
                        state_d    = START;
                        load_cnt_d = '0;
                        enable_d   = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        load_cnt_d = load_cnt_q + 8'd1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
                wd_d    = WD_W'(1);
            end
            WAIT: begin
                // wd_q numbers the current WAIT cycle; hash_done beats the limit
                if (hash_done) begin
                    state_d    = SEND;
                    cap_d      = hash;
                    tx_data_d  = hash[7:0];
                    tx_valid_d = 1'b1;
                    send_cnt_d = '0;
                    wd_d       = '0;
                end else if (wd_q == WD_LIMIT) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    wd_d      = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            SEND: begin
                tx_valid_d = 1'b1;
                if (tx_valid_q && tx_ready) begin
                    if (send_cnt_q == LAST_HASH) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        send_cnt_d = '0;
                    end else begin
                        send_cnt_d = send_nxt;
                        tx_data_d  = cap_q[{send_nxt, 3'b000} +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            send_cnt_q <= '0;
            wd_q       <= '0;
            pass_q     <= '0;
            salt_q     <= '0;
            cap_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            enable_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            send_cnt_q <= send_cnt_d;
            wd_q       <= wd_d;
            pass_q     <= pass_d;
            salt_q     <= salt_d;
            cap_q      <= cap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            enable_q   <= enable_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pass     = pass_q;
    assign salt     = salt_q;
    assign enable   = enable_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_pbkdf2_job_ctrl.sv
// Self-checking bench for pbkdf2_job_ctrl: randomized jobs checked every cycle
// against a job-level model, plus directed watchdog and reset scenarios.
module tb_pbkdf2_job_ctrl;

    localparam int M_WL = 65535;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [639:0]  pass;
    logic [1023:0] salt;
    logic          enable;
    logic [255:0]  hash = '0;
    logic          hash_done = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          timeout;

    logic [7:0]    rx_data16 = '0;
    logic          rx_valid16 = 1'b0;
    logic          rx_ready16;
    logic [639:0]  pass16;
    logic [1023:0] salt16;
    logic          enable16;
    logic [255:0]  hash16 = '0;
    logic          hash_done16 = 1'b0;
    logic [7:0]    tx_data16;
    logic          tx_valid16;
    logic          tx_ready16 = 1'b0;
    logic          busy16;
    logic          timeout16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pbkdf2_job_ctrl u_dut (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .pass(pass), .salt(salt), .enable(enable),
        .hash(hash), .hash_done(hash_done), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .timeout(timeout)
    );

    pbkdf2_job_ctrl #(.WAIT_LIMIT(16)) u_dut16 (
        .clk(clk), .n_rst(n_rst), .rx_data(rx_data16), .rx_valid(rx_valid16),
        .rx_ready(rx_ready16), .pass(pass16), .salt(salt16), .enable(enable16),
        .hash(hash16), .hash_done(hash_done16), .tx_data(tx_data16), .tx_valid(tx_valid16),
        .tx_ready(tx_ready16), .busy(busy16), .timeout(timeout16)
    );

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 50) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 50) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- job-level reference model ----------------
    // m_cnt: bytes of the current job received; m_wait: completed WAIT cycles
    // (-1 when not waiting); m_txq: digest bytes still to be delivered.
    logic [639:0]  m_pass = '0;
    logic [1023:0] m_salt = '0;
    int            m_cnt = 0;
    bit            m_start = 1'b0;
    int            m_wait = -1;
    bit            m_to = 1'b0;
    logic [7:0]    m_last = '0;
    logic [7:0]    m_txq[$];

    function automatic bit m_sending();
        return m_txq.size() > 0;
    endfunction
    function automatic bit m_rdy();
        return !(m_start || (m_wait >= 0) || m_sending());
    endfunction
    function automatic bit m_busy();
        return (m_cnt > 0) || m_start || (m_wait >= 0) || m_sending();
    endfunction
    function automatic logic [7:0] m_txd();
        return m_sending() ? m_txq[0] : m_last;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                m_pass = '0; m_salt = '0; m_cnt = 0; m_start = 1'b0;
                m_wait = -1; m_to = 1'b0; m_last = '0; m_txq.delete();
            end else begin
                bit was_start, was_send, rdy;
                int was_wait;
                was_start = m_start; was_wait = m_wait;
                was_send = m_sending(); rdy = m_rdy();
                m_to = 1'b0;
                m_start = 1'b0;
                if (rdy && rx_valid) begin
                    if (m_cnt < 80) m_pass[8*m_cnt +: 8] = rx_data;
                    else            m_salt[8*(m_cnt-80) +: 8] = rx_data;
                    m_cnt++;
                    if (m_cnt == 208) begin
                        m_cnt = 0;
                        m_start = 1'b1;
                    end
                end else if (was_start) begin
                    m_wait = 0;
                end else if (was_wait >= 0) begin
                    if (hash_done) begin
                        for (int j = 0; j < 32; j++) m_txq.push_back(hash[8*j +: 8]);
                        m_wait = -1;
                    end else begin
                        m_wait++;
                        if (m_wait == M_WL) begin
                            m_wait = -1;
                            m_to = 1'b1;
                        end
                    end
                end else if (was_send && tx_ready) begin
                    m_last = m_txq.pop_front();
                end
            end
        end
    end

    // every-cycle comparison of the DUT against the model
    initial begin
        forever begin
            @(negedge clk);
            chk_int("rx_ready", int'(rx_ready), int'(m_rdy()));
            chk_int("busy", int'(busy), int'(m_busy()));
            chk_int("enable", int'(enable), int'(m_start));
            chk_int("timeout", int'(timeout), int'(m_to));
            chk_int("tx_valid", int'(tx_valid), int'(m_sending()));
            chk_int("tx_data", int'(tx_data), int'(m_txd()));
            chk_vec("pass_lo", pass[319:0], m_pass[319:0]);
            chk_vec("pass_hi", pass[639:320], m_pass[639:320]);
            for (int c = 0; c < 4; c++)
                chk_vec($sformatf("salt_%0d", c), {64'h0, salt[256*c +: 256]}, {64'h0, m_salt[256*c +: 256]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_reset();
        #2 n_rst = 1'b0;
        #1;
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_enable", int'(enable), 0);
        chk_int("rst_tx_valid", int'(tx_valid), 0);
        chk_int("rst_tx_data", int'(tx_data), 0);
        chk_int("rst_timeout", int'(timeout), 0);
        chk_vec("rst_pass_lo", pass[319:0], '0);
        chk_vec("rst_salt_0", {64'h0, salt[255:0]}, '0);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk_int("rx_ready_after_rst", int'(rx_ready), 1);
    endtask

    // dmode: 0 all 8'h01, 1 byte n = n mod 256, 2 random; vmode: 0 always valid,
    // 1 low every other cycle, 2 random. Returns at the negedge driving the last byte.
    task automatic run_job(input int dmode, input int vmode, input int stop_at, input bit noise);
        int i, t, txv;
        bit v, tog;
        i = 0; t = 0; txv = 0; tog = 1'b0;
        while (i < stop_at && t < 5000) begin
            @(negedge clk);
            t++;
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            rx_valid = v;
            case (dmode)
                0:       rx_data = 8'h01;
                1:       rx_data = 8'(i);
                default: rx_data = 8'($urandom);
            endcase
            if (noise) begin
                hash_done = ($urandom_range(0, 2) == 0);
                hash = rand256();
            end
            if (tx_valid) txv++;
            if (v && rx_ready) i++;
        end
        chk_int("load_done", i, stop_at);
        chk_int("no_send_in_load", txv, 0);
    endtask

    // tmode: 0 tx_ready toggles 1/0, 1 random, 2 always high; rst_at >= 0 resets at that byte
    task automatic respond(input int delay, input logic [255:0] h, input int tmode,
                           input int rst_at, output logic [255:0] got);
        int lat, n, t;
        bit found, tog;
        lat = 0; n = 0; t = 0; found = 1'b0; tog = 1'b0; got = '0;
        while (!found && lat < 50) begin
            @(negedge clk);
            lat++;
            rx_valid = 1'b0;
            hash_done = 1'b0;
            if (enable) found = 1'b1;
        end
        chk_int("enable_seen", int'(found), 1);
        if (!found) return;
        chk_int("enable_latency", lat, 1);
        chk_int("rx_ready_in_start", int'(rx_ready), 0);
        @(negedge clk);
        chk_int("enable_width", int'(enable), 0);
        repeat (delay - 1) @(negedge clk);
        hash_done = 1'b1;
        hash = h;
        while (n < 32 && t < 800) begin
            @(negedge clk);
            t++;
            hash_done = 1'b0;
            hash = rand256();
            if (rst_at >= 0 && n == rst_at) begin
                tx_ready = 1'b0;
                pulse_reset();
                return;
            end
            case (tmode)
                0:       begin tog = !tog; tx_ready = tog; end
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
            if (tx_valid && tx_ready) begin
                got[8*n +: 8] = tx_data;
                n++;
            end
        end
        chk_int("tx_count", n, 32);
        @(negedge clk);
        tx_ready = 1'b0;
        chk_int("busy_after_send", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [255:0]  h, got, pat;
        logic [639:0]  ones_p;
        logic [1023:0] ones_s;
        int            q;

        for (int j = 0; j < 32; j++) pat[8*j +: 8] = 8'(j);
        ones_p = {80{8'h01}};
        ones_s = {128{8'h01}};

        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_rx_ready", int'(rx_ready), 1);
        chk_int("reset_tx_valid", int'(tx_valid), 0);
        chk_vec("reset_salt_3", {64'h0, salt[1023:768]}, '0);

        // all-ones job, always valid, pattern digest with toggled tx_ready
        run_job(0, 0, 208, 1'b0);
        respond(20, pat, 0, -1, got);
        chk_vec("job1_pass_lo", pass[319:0], ones_p[319:0]);
        chk_vec("job1_pass_hi", pass[639:320], ones_p[639:320]);
        chk_vec("job1_salt_lo", {64'h0, salt[255:0]}, {64'h0, ones_s[255:0]});
        chk_vec("job1_salt_hi", {64'h0, salt[1023:768]}, {64'h0, ones_s[1023:768]});
        chk_vec("job1_tx_stream", {64'h0, got}, {64'h0, pat});

        // counting bytes with rx_valid low every other cycle
        h = rand256();
        run_job(1, 1, 208, 1'b0);
        respond(20, h, 2, -1, got);
        chk_int("job2_pass_first", int'(pass[7:0]), 8'h00);
        chk_int("job2_pass_last", int'(pass[639:632]), 8'h4F);
        chk_int("job2_salt_first", int'(salt[7:0]), 8'h50);
        chk_int("job2_salt_last", int'(salt[1023:1016]), 8'hCF);
        chk_vec("job2_tx_stream", {64'h0, got}, {64'h0, h});

        // hash_done noise during loading must be ignored
        h = rand256();
        run_job(2, 2, 208, 1'b1);
        respond(5, h, 1, -1, got);
        chk_vec("job3_tx_stream", {64'h0, got}, {64'h0, h});

        // reset after byte 100, then a job reset mid-SEND at byte 10
        run_job(2, 0, 101, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        pulse_reset();
        run_job(2, 2, 208, 1'b0);
        respond(20, rand256(), 0, 10, got);
        q = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid || enable) q++;
        end
        chk_int("quiet_after_rst", q, 0);
        h = rand256();
        run_job(2, 0, 208, 1'b0);
        respond(20, h, 2, -1, got);
        chk_vec("post_rst_tx_stream", {64'h0, got}, {64'h0, h});

        // randomized jobs
        for (int r = 0; r < 5; r++) begin
            h = rand256();
            run_job(2, $urandom_range(0, 2), 208, 1'($urandom_range(0, 1)));
            respond($urandom_range(1, 60), h, $urandom_range(0, 2), -1, got);
            chk_vec("rand_tx_stream", {64'h0, got}, {64'h0, h});
        end

        // watchdog instance (WAIT_LIMIT=16): no hash_done
        begin
            int i, t, kto, tcount, txc;
            bit bprev, b_at, bbefore;
            i = 0; t = 0; kto = -1; tcount = 0; txc = 0;
            bprev = 1'b0; b_at = 1'b1; bbefore = 1'b0;
            while (i < 208 && t < 1000) begin
                @(negedge clk);
                t++;
                rx_valid16 = 1'b1;
                rx_data16 = 8'($urandom);
                if (rx_ready16) i++;
            end
            chk_int("wd_load", i, 208);
            for (int k = 0; k <= 30; k++) begin
                @(negedge clk);
                rx_valid16 = 1'b0;
                if (k == 0) chk_int("wd_enable", int'(enable16), 1);
                if (timeout16) begin
                    tcount++;
                    if (kto < 0) begin
                        kto = k; b_at = busy16; bbefore = bprev;
                    end
                end
                if (tx_valid16) txc++;
                bprev = busy16;
            end
            chk_int("wd_timeout_after_wait_entry", kto - 1, 16);
            chk_int("wd_busy_at_timeout", int'(b_at), 0);
            chk_int("wd_busy_before_timeout", int'(bbefore), 1);
            chk_int("wd_timeout_width", tcount, 1);
            chk_int("wd_no_tx", txc, 0);
        end

        // watchdog instance: hash_done in the last WAIT cycle wins over the limit
        begin
            int i, t, tcount, xfers;
            logic [255:0] h16;
            i = 0; t = 0; tcount = 0; xfers = 0;
            h16 = rand256();
            while (i < 208 && t < 1000) begin
                @(negedge clk);
                t++;
                rx_valid16 = 1'b1;
                rx_data16 = 8'($urandom);
                if (rx_ready16) i++;
            end
            for (int k = 0; k <= 55; k++) begin
                @(negedge clk);
                rx_valid16 = 1'b0;
                hash_done16 = 1'b0;
                if (k == 0) chk_int("wd2_enable", int'(enable16), 1);
                if (k == 16) begin
                    hash_done16 = 1'b1;
                    hash16 = h16;
                end
                if (k == 17) begin
                    chk_int("wd2_tx_valid", int'(tx_valid16), 1);
                    chk_int("wd2_first_byte", int'(tx_data16), int'(h16[7:0]));
                end
                if (timeout16) tcount++;
                if (k >= 17) begin
                    tx_ready16 = 1'b1;
                    if (tx_valid16) xfers++;
                end
            end
            tx_ready16 = 1'b0;
            chk_int("wd2_no_timeout", tcount, 0);
            chk_int("wd2_xfers", xfers, 32);
            chk_int("wd2_idle", int'(busy16), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
